// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and access-size decoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Access size in bytes; reserved encodings decode as a word but are
    // rejected before any memory access happens.
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we)
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            return (funct3 == F3_B)  || (funct3 == F3_H)  || (funct3 == F3_W) ||
                   (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane math: lane masks, store-data positioning, split
// and misalignment detection, and load-data extraction with extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic [7:0]  lanes8,
    output logic [63:0] wide_wdata,
    output logic        split,
    output logic        misalign,
    output logic [31:0] load_data
);

    logic [7:0]  base;
    logic [31:0] rd_word;

    always_comb begin
        case (size_bytes(funct3))
            3'd1:    base = 8'h01;
            3'd2:    base = 8'h03;
            default: base = 8'h0F;
        endcase
        lanes8     = base << off;
        split      = |lanes8[7:4];
        misalign   = ((funct3[1:0] == 2'b01) && off[0]) ||
                     ((funct3[1:0] == 2'b10) && (off != 2'b00));
        wide_wdata = {32'h0, wdata} << {off, 3'b000};
    end

    always_comb begin
        rd_word = 32'({word1, word0} >> {off, 3'b000});
        case (funct3)
            F3_B:    load_data = {{24{rd_word[7]}}, rd_word[7:0]};
            F3_BU:   load_data = {24'h0, rd_word[7:0]};
            F3_H:    load_data = {{16{rd_word[15]}}, rd_word[15:0]};
            F3_HU:   load_data = {16'h0, rd_word[15:0]};
            F3_W:    load_data = rd_word;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between execute stage and word-addressed data memory;
// splits word-crossing accesses into two memory cycles.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter logic ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_cs,
    output logic        mem_rd_wr,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word0_q;
    logic [31:0] word1_q;
    logic        err_q;

    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [7:0]  lanes8;
    logic [63:0] wide_wdata;
    logic        split;
    logic        misalign;
    logic [31:0] load_data;
    logic        req_bad;

    // One aligner serves both the accept-time checks (live request in IDLE)
    // and the access/response phases (latched request otherwise).
    assign al_f3  = (state_q == IDLE) ? req_funct3     : f3_q;
    assign al_off = (state_q == IDLE) ? req_addr[1:0]  : addr_q[1:0];

    lsu_lane_align u_align (
        .funct3     (al_f3),
        .off        (al_off),
        .wdata      (wdata_q),
        .word0      (word0_q),
        .word1      (word1_q),
        .lanes8     (lanes8),
        .wide_wdata (wide_wdata),
        .split      (split),
        .misalign   (misalign),
        .load_data  (load_data)
    );

    assign req_bad = !funct3_legal(req_we, req_funct3) ||
                     ((ALLOW_MISALIGNED == 1'b0) && misalign);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word0_q <= '0;
            word1_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_bad;
                        state_q <= req_bad ? RESP : ACC0;
                    end
                end
                ACC0: begin
                    if (!we_q)
                        word0_q <= mem_rdata;
                    state_q <= split ? ACC1 : RESP;
                end
                ACC1: begin
                    if (!we_q)
                        word1_q <= mem_rdata;
                    state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory strobes decode from registered state only, so they settle well
    // before the memory's negedge write and drop as soon as reset hits.
    always_comb begin
        mem_cs    = 1'b1;
        mem_rd_wr = 1'b1;
        mem_mask  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ACC0: begin
                mem_cs    = 1'b0;
                mem_rd_wr = ~we_q;
                mem_mask  = we_q ? lanes8[3:0] : 4'b0000;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = wide_wdata[31:0];
            end
            ACC1: begin
                mem_cs    = 1'b0;
                mem_rd_wr = ~we_q;
                mem_mask  = we_q ? lanes8[7:4] : 4'b0000;
                mem_addr  = {addr_q[31:2] + 30'd1, 2'b00};
                mem_wdata = wide_wdata[63:32];
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = (state_q == RESP) && err_q;
    assign rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? load_data : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: a byte-level load model and a
// negedge-write memory, plus a second instance with misaligned access disabled.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_cs, mem_rd_wr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        req_valid0, req_ready0, req_we0;
    logic [2:0]  req_funct30;
    logic [31:0] req_addr0, req_wdata0;
    logic        rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;
    logic        mem_cs0, mem_rd_wr0;
    logic [3:0]  mem_mask0;
    logic [31:0] mem_addr0, mem_wdata0;
    logic [31:0] mem_rdata0 = 32'h1234_5678;

    logic [31:0] mem [16];
    int unsigned n_chk = 0;
    int unsigned n_bad = 0;
    int unsigned cs0_low = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
        time         t_acc;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_cs(mem_cs), .mem_rd_wr(mem_rd_wr), .mem_mask(mem_mask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    lsu_mem_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_funct3(req_funct30), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .mem_cs(mem_cs0), .mem_rd_wr(mem_rd_wr0), .mem_mask(mem_mask0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    assign mem_rdata = mem[mem_addr[5:2]];

    always @(negedge clk) begin
        if (!mem_cs && !mem_rd_wr)
            for (int i = 0; i < 4; i++)
                if (mem_mask[i])
                    mem[mem_addr[5:2]][8*i +: 8] = mem_wdata[8*i +: 8];
        if (!mem_cs0)
            cs0_low++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
        end
    endtask

    task automatic mem_init();
        mem[0] = 32'h4433_2211;
        mem[1] = 32'h8877_6655;
        for (int i = 2; i < 16; i++)
            mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5C3_0000;
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [7:0] b [4];
        logic [5:0] ba;
        for (int i = 0; i < 4; i++) begin
            ba   = 6'(a + 32'(i));
            b[i] = mem[ba[5:2]][{ba[1:0], 3'b000} +: 8];
        end
        case (f3)
            F3_B:    return {{24{b[0][7]}}, b[0]};
            F3_BU:   return {24'h0, b[0]};
            F3_H:    return {{16{b[1][7]}}, b[1], b[0]};
            F3_HU:   return {16'h0, b[1], b[0]};
            F3_W:    return {b[3], b[2], b[1], b[0]};
            default: return 32'h0;
        endcase
    endfunction

    // Returns one time step after the accepting edge, with the request dropped.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input int unsigned exp_lat, input logic track);
        exp_t e;
        int unsigned waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        if (track) begin
            e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat; e.t_acc = $time;
            sb_q.push_back(e);
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic issue0(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int unsigned exp_lat);
        int unsigned k = 0;
        @(negedge clk);
        req_valid0 = 1'b1; req_we0 = we; req_funct30 = f3; req_addr0 = addr; req_wdata0 = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 req_valid0 = 1'b0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid0 && k < 8);
        chk("m0_latency", k, exp_lat);
        chk("m0_rdata", rsp_rdata0, exp_rd);
        chk("m0_err", 32'(rsp_err0), 32'(exp_err));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_latency", 32'(($time - e.t_acc + 5) / 10), e.lat);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f3_tab [5];
        logic [2:0]  f3;
        logic [31:0] a;
        int unsigned n, waited;

        f3_tab = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        mem_init();
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_funct30 = '0; req_addr0 = '0; req_wdata0 = '0;

        #3;
        chk("rst_cs", 32'(mem_cs), 32'd1);
        chk("rst_rd_wr", 32'(mem_rd_wr), 32'd1);
        chk("rst_mask", 32'(mem_mask), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_ready", 32'(req_ready), 32'd1);

        issue(1'b0, F3_W, 32'h0, 32'h0, 32'h4433_2211, 1'b0, 2, 1'b1);
        @(negedge clk);
        chk("lw0_addr", mem_addr, 32'h0);
        chk("lw0_cs", 32'(mem_cs), 32'd0);
        chk("lw0_rd_wr", 32'(mem_rd_wr), 32'd1);

        issue(1'b0, F3_B,  32'h3, 32'h0, 32'h0000_0044, 1'b0, 2, 1'b1);
        issue(1'b0, F3_B,  32'h7, 32'h0, 32'hFFFF_FF88, 1'b0, 2, 1'b1);
        issue(1'b0, F3_BU, 32'h7, 32'h0, 32'h0000_0088, 1'b0, 2, 1'b1);
        issue(1'b0, F3_HU, 32'h6, 32'h0, 32'h0000_8877, 1'b0, 2, 1'b1);

        issue(1'b0, F3_W, 32'h2, 32'h0, 32'h6655_4433, 1'b0, 3, 1'b1);
        @(negedge clk);
        chk("lw2_addr0", mem_addr, 32'h0);
        @(negedge clk);
        chk("lw2_addr1", mem_addr, 32'h4);

        issue(1'b1, F3_H, 32'h3, 32'h0000_ABCD, 32'h0, 1'b0, 3, 1'b1);
        @(negedge clk);
        chk("sh_acc0_addr", mem_addr, 32'h0);
        chk("sh_acc0_mask", 32'(mem_mask), 32'h8);
        chk("sh_acc0_byte", 32'(mem_wdata[31:24]), 32'hCD);
        chk("sh_acc0_rd_wr", 32'(mem_rd_wr), 32'd0);
        @(negedge clk);
        chk("sh_acc1_addr", mem_addr, 32'h4);
        chk("sh_acc1_mask", 32'(mem_mask), 32'h1);
        chk("sh_acc1_byte", 32'(mem_wdata[7:0]), 32'hAB);
        issue(1'b0, F3_W, 32'h0, 32'h0, 32'hCD33_2211, 1'b0, 2, 1'b1);
        issue(1'b0, F3_W, 32'h4, 32'h0, 32'h8877_66AB, 1'b0, 2, 1'b1);

        issue(1'b0, F3_W, 32'hFFFF_FFFE, 32'h0, ref_load(F3_W, 32'hFFFF_FFFE), 1'b0, 3, 1'b1);
        @(negedge clk);
        chk("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_addr1", mem_addr, 32'h0);

        issue(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        @(negedge clk);
        chk("ill_ld_cs", 32'(mem_cs), 32'd1);
        issue(1'b1, F3_HU, 32'h0, 32'h1234, 32'h0, 1'b1, 1, 1'b1);
        @(negedge clk);
        chk("ill_st_cs", 32'(mem_cs), 32'd1);

        for (int i = 0; i < 10; i++) begin
            f3 = f3_tab[$urandom_range(0, 4)];
            a  = 32'($urandom_range(0, 63));
            n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
            issue(1'b0, f3, a, 32'h0, ref_load(f3, a), 1'b0, (32'(a[1:0]) + n > 4) ? 3 : 2, 1'b1);
        end

        n = cs0_low;
        issue0(1'b0, F3_H, 32'h1, 32'h0, 1'b1, 1);
        issue0(1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 1);
        issue0(1'b1, F3_W, 32'h6, 32'h0, 1'b1, 1);
        chk("m0_err_no_cs", cs0_low, n);
        issue0(1'b0, F3_W, 32'h4, 32'h1234_5678, 1'b0, 2);

        mem_init();
        issue(1'b1, F3_W, 32'h2, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 1'b0);
        @(negedge clk);
        chk("sw_acc0_mask", 32'(mem_mask), 32'hC);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cs", 32'(mem_cs), 32'd1);
        chk("midrst_rsp", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_word0", mem[0], 32'hBEEF_2211);
        chk("midrst_word1", mem[1], 32'h8877_6655);
        issue(1'b0, F3_W, 32'h0, 32'h0, 32'hBEEF_2211, 1'b0, 2, 1'b1);
        issue(1'b0, F3_W, 32'h4, 32'h0, 32'h8877_6655, 1'b0, 2, 1'b1);

        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store sequencer between the core's execute stage and the word-addressed data memory (active-low chip select, read/write select, byte mask, negedge write, combinational read).
- Accepts one RV32I load/store request at a time.
- Generates byte lanes and shifted write data.
- Splits misaligned accesses that cross a word into two word accesses.
- Assembles, sign/zero-extends and returns load data with a valid/ready request handshake and a one-cycle response pulse.

Parameters:
ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses into two accesses; 0 = return error without touching memory.

Ports:
clk  in  1  system clock, rising-edge logic
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept (IDLE only)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data (0 for stores/errors)
rsp_err  out  1  misaligned (when disallowed) or illegal funct3; valid with rsp_valid
mem_cs  out  1  memory chip select, active-low
mem_rd_wr  out  1  1 = read, 0 = write
mem_mask  out  4  byte-lane write enables
mem_addr  out  32  word-aligned memory address
mem_wdata  out  32  lane-positioned write data
mem_rdata  in  32  combinational memory read data

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - mem_cs=1, mem_rd_wr=1, mem_mask=0, mem_addr=0, mem_wdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 after release.
  - All request registers cleared.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/funct3/addr/wdata.
  - Illegal funct3 goes to RESP with err=1. Illegal loads are 011, 110, 111; illegal stores are 011–111.
  - Misaligned with ALLOW_MISALIGNED=0 goes to RESP with err=1. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - Otherwise go to ACC0.
- Lane math:
  - off = addr[1:0]; size n = 1, 2 or 4 bytes.
  - lanes8 = ((1<<n)-1) << off, an 8-bit vector.
  - Split iff lanes8[7:4]≠0.
  - wide_wdata(64) = zero-extended wdata << 8·off.
- ACC0:
  - mem_cs=0, mem_addr={addr[31:2],2'b00}, mem_rd_wr=~we.
  - mem_mask = lanes8[3:0] for stores, 0 for loads; mem_wdata = wide_wdata[31:0].
  - Loads register mem_rdata into word0 at the cycle's rising edge.
  - Goes to ACC1 if split, else RESP.
- ACC1:
  - mem_addr = ACC0 address + 4, wrapping mod 2^32 (0xFFFFFFFC wraps to 0x0).
  - mem_mask = lanes8[7:4] for stores; mem_wdata = wide_wdata[63:32].
  - Loads capture word1. Goes to RESP.
- RESP:
  - mem_cs=1, mask=0.
  - rsp_valid=1 for exactly this cycle.
  - rsp_rdata = ({word1,word0} >> 8·off) truncated to n bytes. LB/LH sign-extend, LBU/LHU zero-extend; forced to 0 for stores or err.
  - Goes to IDLE.
- Latency from the accepting edge:
  - Aligned: rsp_valid 2 cycles later.
  - Split: 3 cycles later.
  - Error: 1 cycle later, with no cycle where mem_cs=0.
- Throughput: ready deasserted outside IDLE; back-to-back requests are spaced by the full sequence. No response backpressure.
- Memory outputs are registered or decoded from state only, so they are stable before the negedge write.
- Reset mid-operation:
  - mem_cs goes to 1 immediately, so no pending negedge write occurs.
  - The response is dropped.
  - If asserted during ACC1 of a split store, the ACC0 bytes remain written. This partial store is accepted.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - lsu_state_t enum: IDLE, ACC0, ACC1, RESP.
  - Size-decode function.
- Sub-module lsu_lane_align, purely combinational:
  - Inputs funct3 and off; produces lanes8, wide_wdata, split flag and misalign flag.
  - From {word1,word0} produces extended load data.
- The FSM and registers stay in lsu_mem_ctrl.

Test Plan:
Memory preload: word0 = 0x44332211, word1 = 0x88776655.
- LW addr 0x0 → ACC0 with mem_addr=0x0, cs=0, rd_wr=1; rsp_valid 2 cycles after accept; rsp_rdata=0x44332211, err=0.
- Loads at byte offsets:
  - LB 0x3 → 0x00000044.
  - LB 0x7 → 0xFFFFFF88.
  - LBU 0x7 → 0x00000088.
  - LHU 0x6 → 0x00008877.
- LW 0x2 → two accesses at mem_addr 0x0 then 0x4; rsp 3 cycles after accept; rsp_rdata=0x66554433.
- SH 0x3, wdata 0x0000ABCD:
  - ACC0: addr 0x0, mask 1000, mem_wdata[31:24]=0xCD.
  - ACC1: addr 0x4, mask 0001, mem_wdata[7:0]=0xAB.
  - Readback: LW 0 = 0xCD332211, LW 4 = 0x887766AB.
- ALLOW_MISALIGNED=0:
  - LH 0x1 → rsp_err=1, rsp_rdata=0, mem_cs never 0.
  - Load with funct3=011 → err=1 (in either configuration).
- SW 0x2, wdata 0xDEADBEEF, with rst_n pulled low during ACC1:
  - mem_cs=1 asynchronously, no rsp_valid.
  - After release, req_ready=1.
  - Word0 upper half = 0xBEEF, word1 unchanged = 0x88776655.
